spinnaker_fpgas_spi_reg_master: RTL and testbench

SPI-slave-to-register-bus initiator for the SpiNNaker FPGA designs. Decodes serial read/write frames from the board controller's SPI link and drives the top-level register bank interface (write strobe, address, write data; combinational read data back). Sits between the FPGA's SPI pins and the control/diagnostic register bank, serialising register reads back on MISO.

---
 rtl/spinnaker_fpgas_reg_pkg.sv | 21 ++
 rtl/spinnaker_fpgas_spi_sync.sv | 43 ++++
 rtl/spinnaker_fpgas_spi_reg_master.sv | 170 +++++++++++++++++
 tb/tb_spinnaker_fpgas_spi_reg_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spinnaker_fpgas_reg_pkg.sv
// Shared definitions for the SPI register-bus initiator: command encodings, frame field sizes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spinnaker_fpgas_reg_pkg;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam int HDR_BITS  = 16;
  localparam int DATA_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_LATCH,
    ST_DATA,
    ST_WR_ISSUE,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/spinnaker_fpgas_spi_sync.sv
// Two-flop synchronisers for SCLK/MOSI/NSS with SCLK and NSS edge detection on the synchronised values.
// Latency: pin edge visible on *_rise/*_fall after 2 CLK_IN edges, acted on by the consumer at the 3rd.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module spinnaker_fpgas_spi_sync (
  input  logic CLK_IN,
  input  logic RESET_IN,
  input  logic sclk_in,
  input  logic mosi_in,
  input  logic nss_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi,
  output logic nss,
  output logic nss_rise,
  output logic nss_fall
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised value for edge detection
  logic [2:0] sclk_q;
  logic [2:0] nss_q;
  logic [1:0] mosi_q;

  // Sample the asynchronous pins; NSS idles high so it resets high to avoid a false frame start
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      sclk_q <= 3'b000;
      nss_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_in};
      nss_q  <= {nss_q[1:0], nss_in};
      mosi_q <= {mosi_q[0], mosi_in};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign nss_rise  = nss_q[1] & ~nss_q[2];
  assign nss_fall  = ~nss_q[1] & nss_q[2];
  assign mosi      = mosi_q[1];
  assign nss       = nss_q[1];

endmodule

// File: rtl/spinnaker_fpgas_spi_reg_master.sv
// SPI slave frame decoder ({CMD,ADDR} header + 32-bit word) driving the register bank; SPI_REG_MASTER_AUTO_INC_EN enables multi-word frames.
// Latency: 16th header rise -> ADDR_OUT 3 cycles, first MISO bit 5 cycles; last data rise -> WRITE_OUT 4 cycles.
// Backpressure: none; the register bank must accept WRITE_OUT in its single cycle and return READ_DATA_IN combinationally.
module spinnaker_fpgas_spi_reg_master
  import spinnaker_fpgas_reg_pkg::*;
#(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  input  logic                 SPI_SCLK_IN,
  input  logic                 SPI_MOSI_IN,
  input  logic                 SPI_NSS_IN,
  output logic                 SPI_MISO_OUT,
  output logic                 WRITE_OUT,
  output logic [REGA_BITS-1:0] ADDR_OUT,
  output logic [REGD_BITS-1:0] WRITE_DATA_OUT,
  input  logic [REGD_BITS-1:0] READ_DATA_IN
);

  logic sclk_rise;
  logic sclk_fall;
  logic mosi_s;
  logic nss_s;
  logic nss_rise;
  logic nss_fall;

  spinnaker_fpgas_spi_sync u_sync (
    .CLK_IN    (CLK_IN),
    .RESET_IN  (RESET_IN),
    .sclk_in   (SPI_SCLK_IN),
    .mosi_in   (SPI_MOSI_IN),
    .nss_in    (SPI_NSS_IN),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi      (mosi_s),
    .nss       (nss_s),
    .nss_rise  (nss_rise),
    .nss_fall  (nss_fall)
  );

  spi_state_t           state;
  logic [4:0]           bit_cnt;
  logic [1:0]           cmd;
  logic [DATA_BITS-1:0] rx_sr;
  logic [DATA_BITS-1:0] tx_sr;
  logic                 inc_pend;
  logic [HDR_BITS-1:0]  hdr_word;
  logic                 last_hdr_bit;
  logic                 last_data_bit;

  // Header as it will look once the current MOSI bit is shifted in
  assign hdr_word      = {rx_sr[HDR_BITS-2:0], mosi_s};
  assign last_hdr_bit  = (bit_cnt == 5'(HDR_BITS - 1));
  assign last_data_bit = (bit_cnt == 5'(DATA_BITS - 1));

  // Frame FSM with registered bus outputs and MISO
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      cmd            <= '0;
      rx_sr          <= '0;
      tx_sr          <= '0;
      inc_pend       <= 1'b0;
      WRITE_OUT      <= 1'b0;
      ADDR_OUT       <= '0;
      WRITE_DATA_OUT <= '0;
      SPI_MISO_OUT   <= 1'b0;
    end else begin
      WRITE_OUT    <= 1'b0;
      SPI_MISO_OUT <= ((state == ST_DATA) && (cmd == CMD_READ) && !nss_s) ? tx_sr[DATA_BITS-1] : 1'b0;

      // Address bump after a write is deferred one cycle so ADDR_OUT is stable while WRITE_OUT is high
      if (inc_pend) begin
        ADDR_OUT <= ADDR_OUT + REGA_BITS'(1);
        inc_pend <= 1'b0;
      end

      if (sclk_rise && ((state == ST_HDR) || (state == ST_DATA)))
        rx_sr <= {rx_sr[DATA_BITS-2:0], mosi_s};

      case (state)
        // Start only on a fresh NSS fall so a frame already in flight is never picked up half-way
        ST_IDLE: begin
          if (nss_fall) begin
            state   <= ST_HDR;
            bit_cnt <= '0;
          end
        end

        ST_HDR: begin
          if (nss_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            if (last_hdr_bit) begin
              bit_cnt  <= '0;
              ADDR_OUT <= hdr_word[REGA_BITS-1:0];
              cmd      <= hdr_word[HDR_BITS-1 -: 2];
              if (hdr_word[HDR_BITS-1 -: 2] == CMD_READ)       state <= ST_RD_LATCH;
              else if (hdr_word[HDR_BITS-1 -: 2] == CMD_WRITE) state <= ST_DATA;
              else                                             state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        ST_RD_LATCH: begin
          tx_sr   <= READ_DATA_IN;
          bit_cnt <= '0;
          state   <= nss_rise ? ST_IDLE : ST_DATA;
        end

        ST_DATA: begin
          // A complete write word wins over a simultaneous NSS rise
          if (sclk_rise && last_data_bit && (cmd == CMD_WRITE)) begin
            state   <= ST_WR_ISSUE;
            bit_cnt <= '0;
          end else if (nss_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            if (last_data_bit) begin
              bit_cnt <= '0;
`ifdef SPI_REG_MASTER_AUTO_INC_EN
              ADDR_OUT <= ADDR_OUT + REGA_BITS'(1);
              state    <= ST_RD_LATCH;
`else
              state    <= ST_DONE;
`endif
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (sclk_fall && (bit_cnt != 5'd0)) begin
            // Bit 31 is already on MISO before the first data rise; advance only after each data rise
            tx_sr <= {tx_sr[DATA_BITS-2:0], 1'b0};
          end
        end

        ST_WR_ISSUE: begin
          WRITE_OUT      <= 1'b1;
          WRITE_DATA_OUT <= rx_sr;
          bit_cnt        <= '0;
`ifdef SPI_REG_MASTER_AUTO_INC_EN
          inc_pend <= 1'b1;
          state    <= nss_s ? ST_IDLE : ST_DATA;
`else
          state    <= nss_s ? ST_IDLE : ST_DONE;
`endif
        end

        ST_DONE: begin
          if (nss_s) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spinnaker_fpgas_spi_reg_master.sv
// Bench for the SPI register-bus initiator: table of frames plus hand sequences for latency, abort, auto-increment and reset.
// Latency: SPI bit period is 16 CLK_IN cycles.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spinnaker_fpgas_spi_reg_master;

`ifdef SPI_REG_MASTER_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_nss = 1'b1;
  logic        SPI_MISO_OUT;
  logic        WRITE_OUT;
  logic [13:0] ADDR_OUT;
  logic [31:0] WRITE_DATA_OUT;
  logic [31:0] read_data;

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [13:0] a);
    if (a == 14'd0) return 32'hA5C30F01;
    return {a, 2'b10, a, 2'b01} ^ 32'h5A5A0000;
  endfunction

  assign read_data = model_rd(ADDR_OUT);

  spinnaker_fpgas_spi_reg_master #(.REGA_BITS(14), .REGD_BITS(32)) dut (
    .CLK_IN         (clk),
    .RESET_IN       (rst),
    .SPI_SCLK_IN    (spi_sclk),
    .SPI_MOSI_IN    (spi_mosi),
    .SPI_NSS_IN     (spi_nss),
    .SPI_MISO_OUT   (SPI_MISO_OUT),
    .WRITE_OUT      (WRITE_OUT),
    .ADDR_OUT       (ADDR_OUT),
    .WRITE_DATA_OUT (WRITE_DATA_OUT),
    .READ_DATA_IN   (read_data)
  );

  typedef struct packed {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] hdr;
    logic [31:0] data;
    logic        exp_wr;
    logic        valid;
    logic [13:0] exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  wr_t  sb_q[$];
  wr_t  mon_w;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   last_rise_cyc = 0;
  int   hdr_rise_cyc = 0;
  int   last_wr_cyc = 0;
  int   addr_chg_cyc = 0;
  int   miso_rise_cyc = 0;
  logic wr_prev = 1'b0;
  logic miso_any = 1'b0;
  logic miso_armed = 1'b0;
  logic addr_armed = 1'b0;
  logic [13:0] addr_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write scoreboard and latency monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (WRITE_OUT) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      checks++;
      if (wr_prev) begin
        failures++;
        $display("FAIL write_width actual=2+cycles required=1");
      end
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h/%h required=none", ADDR_OUT, WRITE_DATA_OUT);
      end else begin
        mon_w = sb_q.pop_front();
        if ({ADDR_OUT, WRITE_DATA_OUT} !== {mon_w.a, mon_w.d}) begin
          failures++;
          $display("FAIL write_content actual=%h/%h required=%h/%h", ADDR_OUT, WRITE_DATA_OUT, mon_w.a, mon_w.d);
        end
      end
    end
    wr_prev = WRITE_OUT;
    if (SPI_MISO_OUT) miso_any = 1'b1;
    if (miso_armed && SPI_MISO_OUT) begin
      miso_rise_cyc = cyc;
      miso_armed = 1'b0;
    end
    if (addr_armed && (ADDR_OUT != addr_prev)) begin
      addr_chg_cyc = cyc;
      addr_armed = 1'b0;
    end
    addr_prev = ADDR_OUT;
  end

  task automatic spi_bit(input logic v, output logic s);
    spi_mosi = v;
    repeat (8) @(negedge clk);
    s = SPI_MISO_OUT;
    spi_sclk = 1'b1;
    last_rise_cyc = cyc;
    repeat (8) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] hdr, input logic [31:0] d0, input logic [31:0] d1,
                           input int ndata, output logic [31:0] rd);
    logic s;
    logic [63:0] dd;
    dd = {d0, d1};
    @(negedge clk);
    miso_any = 1'b0;
    miso_armed = 1'b1;
    addr_armed = 1'b1;
    spi_nss = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 16; i++) spi_bit(hdr[15-i], s);
    hdr_rise_cyc = last_rise_cyc;
    rd = '0;
    for (int i = 0; i < ndata; i++) begin
      spi_bit(dd[63-i], s);
      if (i < 32) rd = {rd[30:0], s};
    end
    repeat (6) @(negedge clk);
    spi_nss = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vec[10];
    logic [31:0] rd;
    int          wr_before;
    logic        s;

    vec[0] = '{16'h8002, 32'h12345678, 1'b1, 1'b1, 14'h0002, 32'h0};
    vec[1] = '{16'h4000, 32'h00000000, 1'b0, 1'b1, 14'h0000, 32'hA5C30F01};
    vec[2] = '{16'hC002, 32'hFFFFFFFF, 1'b0, 1'b0, 14'h0002, 32'h0};
    vec[3] = '{16'h8005, 32'hDEADBEEF, 1'b1, 1'b1, 14'h0005, 32'h0};
    vec[4] = '{16'h4005, 32'h0000FFFF, 1'b0, 1'b1, 14'h0005, model_rd(14'h0005)};
    vec[5] = '{16'h0007, 32'hAAAAAAAA, 1'b0, 1'b0, 14'h0007, 32'h0};
    vec[6] = '{16'h7FFF, 32'h00000000, 1'b0, 1'b1, 14'h3FFF, model_rd(14'h3FFF)};
    vec[7] = '{16'hBFFF, 32'h0F0F00F0, 1'b1, 1'b1, 14'h3FFF, 32'h0};
    vec[8] = '{16'h4002, 32'h12345678, 1'b0, 1'b1, 14'h0002, model_rd(14'h0002)};
    vec[9] = '{16'h9ABC, 32'h80000001, 1'b1, 1'b1, 14'h1ABC, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_write", 32'(WRITE_OUT), 32'h0);
    chk("rst_addr", 32'(ADDR_OUT), 32'h0);
    chk("rst_wdata", WRITE_DATA_OUT, 32'h0);
    chk("rst_miso", 32'(SPI_MISO_OUT), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table of single-word frames
    for (int i = 0; i < 10; i++) begin
      wr_before = wr_cnt;
      if (vec[i].exp_wr) sb_q.push_back('{vec[i].exp_addr, vec[i].data});
      spi_frame(vec[i].hdr, vec[i].data, 32'h0, 32, rd);
      chk("vec_wr_count", 32'(wr_cnt - wr_before), 32'(vec[i].exp_wr));
      chk("vec_sb_empty", 32'(sb_q.size()), 32'h0);
      chk("vec_miso_word", rd, vec[i].exp_rd);
      if (vec[i].exp_rd == 32'h0) chk("vec_miso_quiet", 32'(miso_any), 32'h0);
      chk("vec_addr", 32'(ADDR_OUT), 32'(vec[i].exp_addr + ((AUTO && vec[i].valid) ? 14'd1 : 14'd0)));
    end

    // Abort after 24 data bits, then a full frame behaves normally
    wr_before = wr_cnt;
    spi_frame(16'h8003, 32'h13572468, 32'h0, 24, rd);
    chk("abort_no_write", 32'(wr_cnt - wr_before), 32'h0);
    sb_q.push_back('{14'h0003, 32'h55AA55AA});
    spi_frame(16'h8003, 32'h55AA55AA, 32'h0, 32, rd);
    chk("after_abort_write", 32'(wr_cnt - wr_before), 32'h1);
    chk("after_abort_sb", 32'(sb_q.size()), 32'h0);

    // Latency: header -> ADDR_OUT and last data rise -> WRITE_OUT
    sb_q.push_back('{14'h0123, 32'hC0FFEE11});
    spi_frame(16'h8123, 32'hC0FFEE11, 32'h0, 32, rd);
    chk("addr_latency", 32'(addr_chg_cyc - hdr_rise_cyc), 32'd3);
    chk("wr_latency", 32'(last_wr_cyc - last_rise_cyc), 32'd4);

    // Latency: header -> first MISO bit of a read
    spi_frame(16'h4000, 32'h0, 32'h0, 32, rd);
    chk("rd_addr_latency", 32'(addr_chg_cyc - hdr_rise_cyc), 32'd3);
    chk("miso_latency", 32'(miso_rise_cyc - hdr_rise_cyc), 32'd5);
    chk("rd_word_addr0", rd, 32'hA5C30F01);

    // Two-word write frame across the address wrap
    wr_before = wr_cnt;
    sb_q.push_back('{14'h3FFF, 32'h11111111});
    if (AUTO) sb_q.push_back('{14'h0000, 32'h22222222});
    spi_frame(16'hBFFF, 32'h11111111, 32'h22222222, 64, rd);
    chk("multi_word_writes", 32'(wr_cnt - wr_before), AUTO ? 32'd2 : 32'd1);
    chk("multi_word_sb", 32'(sb_q.size()), 32'h0);

    // Reset in the middle of a read, after 10 data bits
    wr_before = wr_cnt;
    @(negedge clk);
    spi_nss = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 16; i++) spi_bit(((16'h4001 >> (15 - i)) & 16'h1) != 16'h0, s);
    for (int i = 0; i < 10; i++) spi_bit(1'b0, s);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_write", 32'(WRITE_OUT), 32'h0);
    chk("midrst_addr", 32'(ADDR_OUT), 32'h0);
    chk("midrst_wdata", WRITE_DATA_OUT, 32'h0);
    chk("midrst_miso", 32'(SPI_MISO_OUT), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    spi_nss = 1'b1;
    repeat (20) @(negedge clk);
    spi_frame(16'h4001, 32'h0, 32'h0, 32, rd);
    chk("post_rst_read", rd, model_rd(14'h0001));
    chk("post_rst_addr", 32'(ADDR_OUT), AUTO ? 32'h2 : 32'h1);
    chk("post_rst_no_write", 32'(wr_cnt - wr_before), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
